// File: rtl/palette_pkg.sv
// Shared types and reset defaults for the palette lookup path.
package palette_pkg;

    typedef logic [23:0] rgb_t;

    localparam rgb_t RGB_BLACK = 24'h000000;
    localparam rgb_t RGB_WHITE = 24'hFFFFFF;

    // Entry 0 of every bank is black, all others white.
    function automatic rgb_t entry_default(input int unsigned index);
        return (index == 0) ? RGB_BLACK : RGB_WHITE;
    endfunction

endpackage

// File: rtl/switch_debounce.sv
// Synchronises and debounces an active-low push-button; emits a one-cycle
// pulse on each accepted press (debounced 1->0 transition).
module switch_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d = level_q & ~level_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/palette_lut.sv
// Banked colour-index to RGB888 lookup with a 2-cycle pipeline; the bank
// advances on button presses and switches only at frame boundaries.
module palette_lut
    import palette_pkg::*;
#(
    parameter int unsigned IDX_W           = 2,
    parameter int unsigned NUM_BANKS       = 4,
    parameter int unsigned BANK_W          = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              switch,
    input  logic              frame_start,
    input  logic              wr_en,
    input  logic [BANK_W-1:0] wr_bank,
    input  logic [IDX_W-1:0]  wr_index,
    input  logic [23:0]       wr_colour,
    input  logic              in_valid,
    input  logic [IDX_W-1:0]  in_index,
    output logic              out_valid,
    output logic [23:0]       out_colour,
    output logic [BANK_W-1:0] active_bank
);

    localparam int unsigned DEPTH = 2 ** IDX_W;

    rgb_t              mem_q [NUM_BANKS][DEPTH];
    rgb_t              mem_d [NUM_BANKS][DEPTH];
    logic [BANK_W-1:0] pending_q, pending_d;
    logic [BANK_W-1:0] active_q, active_d;
    logic              s1_valid_q, s1_valid_d;
    logic [IDX_W-1:0]  s1_index_q, s1_index_d;
    logic              out_valid_q, out_valid_d;
    rgb_t              out_colour_q, out_colour_d;
    logic              press;

    switch_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_switch_debounce (
        .clk  (clk),
        .rst  (rst),
        .raw  (switch),
        .press(press)
    );

    always_comb begin
        mem_d = mem_q;
        if (wr_en && (32'(wr_bank) < NUM_BANKS)) begin
            mem_d[wr_bank][wr_index] = wr_colour;
        end
    end

    // A coincident press and frame_start: active takes the old pending value.
    always_comb begin
        pending_d = pending_q;
        active_d  = active_q;
        if (press) begin
            pending_d = (pending_q == BANK_W'(NUM_BANKS - 1)) ? '0 : pending_q + 1'b1;
        end
        if (frame_start) begin
            active_d = pending_q;
        end
    end

    // Stage 2 reads mem_q, so a same-cycle write to the same entry returns the old value.
    always_comb begin
        s1_valid_d   = in_valid;
        s1_index_d   = in_index;
        out_valid_d  = s1_valid_q;
        out_colour_d = out_colour_q;
        if (s1_valid_q) begin
            out_colour_d = mem_q[active_q][s1_index_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    mem_q[b][i] <= entry_default(i);
                end
            end
            pending_q    <= '0;
            active_q     <= '0;
            s1_valid_q   <= 1'b0;
            s1_index_q   <= '0;
            out_valid_q  <= 1'b0;
            out_colour_q <= RGB_BLACK;
        end else begin
            mem_q        <= mem_d;
            pending_q    <= pending_d;
            active_q     <= active_d;
            s1_valid_q   <= s1_valid_d;
            s1_index_q   <= s1_index_d;
            out_valid_q  <= out_valid_d;
            out_colour_q <= out_colour_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_colour  = out_colour_q;
    assign active_bank = active_q;

endmodule

// File: doc/palette_lut.md
Name: palette_lut

Overview:
- Parametrised successor to the fixed 4-colour palette. Maps an IDX_W-bit pixel colour index to a 24-bit RGB value through NUM_BANKS programmable palette banks.
- Bank selection comes from a debounced, falling-edge-detected push-button. The new bank takes effect only at a frame boundary, so the image does not tear.
- Sits between the frame-buffer read port and the video encoder. It runs on the pixel clock.

Parameters:
- IDX_W, 2, width of the colour index; each bank holds 2**IDX_W entries.
- NUM_BANKS, 4, number of palette banks; must be >= 1.
- BANK_W, 2, width of bank select; equal to max(1, clog2(NUM_BANKS)).
- DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples required to accept a switch level change; must be >= 1.

Ports:
- clk  in  1  pixel clock; everything is on its rising edge.
- rst  in  1  synchronous reset, active-high.
- switch  in  1  raw asynchronous push-button, active-low; each press advances the bank.
- frame_start  in  1  single-cycle pulse at the start of each frame.
- wr_en  in  1  palette entry write strobe.
- wr_bank  in  BANK_W  bank to write.
- wr_index  in  IDX_W  entry to write.
- wr_colour  in  24  RGB888 value to write.
- in_valid  in  1  lookup request valid.
- in_index  in  IDX_W  colour index to look up.
- out_valid  out  1  lookup result valid.
- out_colour  out  24  RGB888 result.
- active_bank  out  BANK_W  bank currently used for lookups.

Behaviour:
- Storage:
  - NUM_BANKS x 2**IDX_W x 24-bit registers.
  - Reset loads every bank with entry 0 = 24'h000000 and all other entries = 24'hFFFFFF.
- Reset (rst=1 for any cycle, including mid-frame or mid-debounce):
  - out_valid=0, out_colour=0, active_bank=0.
  - pending bank = 0.
  - Synchroniser flops = 1; debounced level = 1; debounce counter = 0.
  - Pipeline valids cleared.
- Write:
  - When wr_en=1 and wr_bank < NUM_BANKS, entry[wr_bank][wr_index] updates on the clock edge.
  - When wr_bank >= NUM_BANKS, the write is ignored.
  - Writes are accepted in any cycle, including to the active bank.
- Lookup pipeline, fixed 2-cycle latency, no stalls:
  - Stage 1 registers in_valid and in_index.
  - Stage 2 registers out_valid and out_colour = entry[active_bank][stage1 index].
  - When stage-1 valid=0: out_valid=0 and out_colour holds its previous value.
- Write/lookup collision: if stage 2 reads the entry being written in the same cycle, it returns the OLD value. The new value is visible from the next cycle.
- Switch path:
  - 2-flop synchroniser.
  - A counter counts cycles in which the synchronised value differs from the debounced level; it resets to 0 whenever the two are equal.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the synchronised value and the counter clears.
  - A debounced 1->0 transition is one press.
- Bank state machine, two registers (pending, active):
  - On a press: pending <= (pending == NUM_BANKS-1) ? 0 : pending+1. This wraps.
  - On frame_start: active <= pending.
  - Press and frame_start in the same cycle: active takes the pre-increment pending; the increment lands in pending and applies at the next frame_start.
  - Multiple presses within one frame accumulate modulo NUM_BANKS.
- A change of active bank affects lookups whose stage-2 edge occurs after the update. There is no mid-pipeline mixing within one stage.
- NUM_BANKS=1: presses leave pending at 0.

Decomposition:
- Shared package palette_pkg:
  - rgb_t (24-bit) typedef.
  - Constants RGB_BLACK = 24'h000000 and RGB_WHITE = 24'hFFFFFF.
  - Reset-default function entry_default(index).
- Sub-module switch_debounce (params DEBOUNCE_CYCLES):
  - Ports: clk, rst, raw, press (1-cycle pulse).
  - Reused later for other front-panel buttons.
- palette_lut instantiates switch_debounce and holds the storage, bank registers and pipeline.

Test Plan:
- Reset then lookup: in_index=0, then 1, back-to-back with in_valid=1 -> out_valid high 2 cycles later; out_colour = 000000 then FFFFFF; active_bank=0.
- Program and read: write bank0 idx1 = FFB3BA, then look up idx1 -> out_colour = FFB3BA after 2 cycles. Repeat with wr_bank=7 (NUM_BANKS=4) -> write ignored, entry unchanged.
- Collision: write bank0 idx2 = 123456 in the same cycle stage 2 reads idx2 -> old FFFFFF returned; the next lookup returns 123456.
- Debounce: switch low for DEBOUNCE_CYCLES-1 cycles then high -> no press. Switch low for >= DEBOUNCE_CYCLES+2 cycles -> exactly one press, pending=1. active_bank stays 0 until frame_start, then becomes 1.
- Wrap and accumulate: with NUM_BANKS=4, five presses then frame_start -> active_bank=1. Press coincident with frame_start when pending=1 -> active=1 now, pending=2, active=2 at the next frame_start.
- Mid-operation reset: rst asserted with pending=3 and lookups in flight -> next cycle out_valid=0, active_bank=0, palette contents back to defaults.
